// File: rtl/udcounter_ctrl_if.sv
// udcounter_ctrl_if -- command/strobe bundle between a requester and the
// 193-style counter controller.
//   cmd_valid, cmd[1:0], load_val[7:0], clr : requester -> controller
//   cmd_ready                               : controller -> requester
//   cpu, cpd, pl, mr, d[7:0]                : controller -> counter pair
// master = requester side, slave = controller side.
interface udcounter_ctrl_if;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic [7:0] load_val;
  logic       clr;
  logic       cmd_ready;
  logic       cpu;
  logic       cpd;
  logic       pl;
  logic       mr;
  logic [7:0] d;

  modport master (
    output cmd_valid, cmd, load_val, clr,
    input  cmd_ready, cpu, cpd, pl, mr, d
  );

  modport slave (
    input  cmd_valid, cmd, load_val, clr,
    output cmd_ready, cpu, cpd, pl, mr, d
  );
endinterface

// File: rtl/udcounter_ctrl.sv
// udcounter_ctrl -- turns synchronous commands (NOP/INC/DEC/LOAD/clr) into
// glitch-free control strobes for a cascaded pair of 193-style up/down
// counters. Every strobe and d come straight from a flop.
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   bus       udcounter_ctrl_if.slave (command handshake + counter strobes)
//   shadow_q  8-bit expected counter value, only when UDCTL_SHADOW_EN is defined
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for clr or a non-NOP command
// STROBE  | exactly one strobe active (cpu/cpd/pl low or mr high)
// RELEASE | strobes back at idle; INC/DEC counted on the edge entering here
// GAP     | settle cycle before accepting the next command
module udcounter_ctrl (
  input  logic clk,
  input  logic rst_n,
  udcounter_ctrl_if.slave bus
`ifdef UDCTL_SHADOW_EN
  ,
  output logic [7:0] shadow_q
`endif
);

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_INC  = 2'b01;
  localparam logic [1:0] CMD_DEC  = 2'b10;
  localparam logic [1:0] CMD_LOAD = 2'b11;

  typedef enum logic [1:0] {IDLE, STROBE, RELEASE, GAP} state_t;

  state_t     state, state_nxt;
  logic       cpu_q, cpu_nxt;
  logic       cpd_q, cpd_nxt;
  logic       pl_q, pl_nxt;
  logic       mr_q, mr_nxt;
  logic [7:0] d_q, d_nxt;

  // mr resets high so the counters stay cleared through reset; it drops on
  // the first edge after release because IDLE computes mr_nxt = 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cpu_q <= 1'b1;
      cpd_q <= 1'b1;
      pl_q  <= 1'b1;
      mr_q  <= 1'b1;
      d_q   <= 8'h00;
    end else begin
      state <= state_nxt;
      cpu_q <= cpu_nxt;
      cpd_q <= cpd_nxt;
      pl_q  <= pl_nxt;
      mr_q  <= mr_nxt;
      d_q   <= d_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cpu_nxt   = 1'b1;
    cpd_nxt   = 1'b1;
    pl_nxt    = 1'b1;
    mr_nxt    = 1'b0;
    d_nxt     = d_q;
    case (state)
      IDLE: begin
        if (bus.clr) begin
          mr_nxt    = 1'b1;
          state_nxt = STROBE;
        end else if (bus.cmd_valid && (bus.cmd != CMD_NOP)) begin
          state_nxt = STROBE;
          case (bus.cmd)
            CMD_INC:  cpu_nxt = 1'b0;
            CMD_DEC:  cpd_nxt = 1'b0;
            CMD_LOAD: begin
              pl_nxt = 1'b0;
              d_nxt  = bus.load_val;
            end
            default: ;
          endcase
        end
      end
      STROBE:  state_nxt = RELEASE;
      RELEASE: state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.cpu       = cpu_q;
  assign bus.cpd       = cpd_q;
  assign bus.pl        = pl_q;
  assign bus.mr        = mr_q;
  assign bus.d         = d_q;

`ifdef UDCTL_SHADOW_EN
  // During STROBE the strobe flops themselves identify the operation, so no
  // separate opcode register is needed; the update lands on the RELEASE edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= 8'h00;
    end else if (state == STROBE) begin
      if (mr_q)       shadow_q <= 8'h00;
      else if (!pl_q)  shadow_q <= d_q;
      else if (!cpu_q) shadow_q <= shadow_q + 8'd1;
      else if (!cpd_q) shadow_q <= shadow_q - 8'd1;
    end
  end
`endif

endmodule
